// File: rtl/fp_unit_sequencer_if.sv
// Bus bundle between the FP issue stage, the Fp32Unit datapath, the result
// consumer and the fflags CSR port of the sequencer.
interface fp_unit_sequencer_if #(
  parameter int UNIT_W = 4,
  parameter int TAG_W  = 5
);
  logic              flush;
  logic              reqValid;
  logic              reqReady;
  logic [UNIT_W-1:0] reqUnit;
  logic [TAG_W-1:0]  reqTag;
  logic [UNIT_W-1:0] fpUnit;
  logic              fpEnable;
  logic              fpFlush;
  logic              fpDone;
  logic [31:0]       fpIntResult;
  logic [31:0]       fpFpResult;
  logic              fpWriteFlags;
  logic [4:0]        fpFlagsValue;
  logic              respValid;
  logic              respReady;
  logic [TAG_W-1:0]  respTag;
  logic [31:0]       respIntResult;
  logic [31:0]       respFpResult;
  logic              respTimeout;
  logic [4:0]        fflags;
  logic              fflagsWrite;
  logic [4:0]        fflagsWriteValue;

  // Environment side: issue stage, datapath results, consumer and CSR writer.
  modport master (
    output flush, reqValid, reqUnit, reqTag,
    output fpDone, fpIntResult, fpFpResult, fpWriteFlags, fpFlagsValue,
    output respReady, fflagsWrite, fflagsWriteValue,
    input  reqReady, fpUnit, fpEnable, fpFlush,
    input  respValid, respTag, respIntResult, respFpResult, respTimeout, fflags
  );

  // Sequencer side.
  modport slave (
    input  flush, reqValid, reqUnit, reqTag,
    input  fpDone, fpIntResult, fpFpResult, fpWriteFlags, fpFlagsValue,
    input  respReady, fflagsWrite, fflagsWriteValue,
    output reqReady, fpUnit, fpEnable, fpFlush,
    output respValid, respTag, respIntResult, respFpResult, respTimeout, fflags
  );
endinterface

// File: rtl/fp_unit_sequencer.sv
// Issue/commit sequencer for the Fp32Unit: runs one op at a time, holds the
// unit select until done or watchdog abort, and commits flags into fflags.
module fp_unit_sequencer #(
  parameter int                UNIT_W    = 4,
  parameter int                TAG_W     = 5,
  parameter logic [UNIT_W-1:0] IDLE_UNIT = 4'hF,
  parameter int                TIMEOUT   = 64
) (
  input logic             clk,
  input logic             rst,
  fp_unit_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seqState_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  seqState_t         state_r;
  logic [7:0]        count_r;
  logic [TAG_W-1:0]  tag_r;
  logic              reqReady_r;
  logic              fpEnable_r;
  logic [UNIT_W-1:0] fpUnit_r;
  logic              respValid_r;
  logic [TAG_W-1:0]  respTag_r;
  logic [31:0]       respIntResult_r;
  logic [31:0]       respFpResult_r;
  logic              respTimeout_r;
  logic              capWriteFlags_r;
  logic [4:0]        capFlags_r;
  logic [4:0]        fflags_r;

  logic              timeoutHit_s;
  logic              commit_s;
  logic [4:0]        commitFlags_s;

  // The abort must reach the datapath in the same cycle it is decided,
  // so the flush strobe is decoded from registered state plus live inputs.
  assign timeoutHit_s  = (state_r == EXEC) && (count_r == LAST_CNT) && !bus.fpDone;
  assign commit_s      = (state_r == RESP) && bus.respReady && !bus.flush;
  assign commitFlags_s = (commit_s && capWriteFlags_r) ? capFlags_r : 5'b00000;

  assign bus.fpFlush       = !rst && (bus.flush || timeoutHit_s);
  assign bus.reqReady      = reqReady_r;
  assign bus.fpEnable      = fpEnable_r;
  assign bus.fpUnit        = fpUnit_r;
  assign bus.respValid     = respValid_r;
  assign bus.respTag       = respTag_r;
  assign bus.respIntResult = respIntResult_r;
  assign bus.respFpResult  = respFpResult_r;
  assign bus.respTimeout   = respTimeout_r;
  assign bus.fflags        = fflags_r;

  // Sequencer FSM with registered handshake, unit-select and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r         <= IDLE;
      count_r         <= 8'd0;
      tag_r           <= '0;
      reqReady_r      <= 1'b1;
      fpEnable_r      <= 1'b0;
      fpUnit_r        <= IDLE_UNIT;
      respValid_r     <= 1'b0;
      respTag_r       <= '0;
      respIntResult_r <= 32'd0;
      respFpResult_r  <= 32'd0;
      respTimeout_r   <= 1'b0;
      capWriteFlags_r <= 1'b0;
      capFlags_r      <= 5'b00000;
    end else if (bus.flush) begin
      state_r         <= IDLE;
      reqReady_r      <= 1'b1;
      fpEnable_r      <= 1'b0;
      fpUnit_r        <= IDLE_UNIT;
      respValid_r     <= 1'b0;
      capWriteFlags_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.reqValid) begin
            state_r    <= EXEC;
            count_r    <= 8'd0;
            tag_r      <= bus.reqTag;
            reqReady_r <= 1'b0;
            fpEnable_r <= 1'b1;
            fpUnit_r   <= bus.reqUnit;
          end
        end
        EXEC: begin
          if (bus.fpDone) begin
            state_r         <= RESP;
            fpEnable_r      <= 1'b0;
            fpUnit_r        <= IDLE_UNIT;
            respValid_r     <= 1'b1;
            respTag_r       <= tag_r;
            respIntResult_r <= bus.fpIntResult;
            respFpResult_r  <= bus.fpFpResult;
            respTimeout_r   <= 1'b0;
            capWriteFlags_r <= bus.fpWriteFlags;
            capFlags_r      <= bus.fpFlagsValue;
          end else if (count_r == LAST_CNT) begin
            // Watchdog abort: the response carries no data and no flags.
            state_r         <= RESP;
            fpEnable_r      <= 1'b0;
            fpUnit_r        <= IDLE_UNIT;
            respValid_r     <= 1'b1;
            respTag_r       <= tag_r;
            respIntResult_r <= 32'd0;
            respFpResult_r  <= 32'd0;
            respTimeout_r   <= 1'b1;
            capWriteFlags_r <= 1'b0;
            capFlags_r      <= 5'b00000;
          end else begin
            count_r <= count_r + 8'd1;
          end
        end
        RESP: begin
          if (bus.respReady) begin
            state_r     <= IDLE;
            respValid_r <= 1'b0;
            reqReady_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          reqReady_r  <= 1'b1;
          fpEnable_r  <= 1'b0;
          fpUnit_r    <= IDLE_UNIT;
          respValid_r <= 1'b0;
        end
      endcase
    end
  end

  // Architectural fflags: CSR write merges with any flags committing that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_r <= 5'b00000;
    end else if (bus.fflagsWrite) begin
      fflags_r <= bus.fflagsWriteValue | commitFlags_s;
    end else begin
      fflags_r <= fflags_r | commitFlags_s;
    end
  end

endmodule

// File: tb/tb_fp_unit_sequencer.sv
// Directed bench for fp_unit_sequencer: main instance with the default
// watchdog plus a second instance with TIMEOUT=8 for the abort path.
module tb_fp_unit_sequencer;

  localparam logic [3:0] UNIT_MOVE = 4'd5;
  localparam logic [3:0] UNIT_SQRT = 4'd7;
  localparam logic [3:0] UNIT_IDLE = 4'hF;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fp_unit_sequencer_if #(.UNIT_W(4), .TAG_W(5)) bus ();
  fp_unit_sequencer_if #(.UNIT_W(4), .TAG_W(5)) busWd ();

  fp_unit_sequencer #(.UNIT_W(4), .TAG_W(5), .IDLE_UNIT(4'hF), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  fp_unit_sequencer #(.UNIT_W(4), .TAG_W(5), .IDLE_UNIT(4'hF), .TIMEOUT(8)) dutWd (
    .clk(clk), .rst(rst), .bus(busWd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.flush = 1'b0; bus.reqValid = 1'b0; bus.reqUnit = 4'd0; bus.reqTag = 5'd0;
    bus.fpDone = 1'b0; bus.fpIntResult = 32'd0; bus.fpFpResult = 32'd0;
    bus.fpWriteFlags = 1'b0; bus.fpFlagsValue = 5'd0; bus.respReady = 1'b0;
    bus.fflagsWrite = 1'b0; bus.fflagsWriteValue = 5'd0;
    busWd.flush = 1'b0; busWd.reqValid = 1'b0; busWd.reqUnit = 4'd0; busWd.reqTag = 5'd0;
    busWd.fpDone = 1'b0; busWd.fpIntResult = 32'd0; busWd.fpFpResult = 32'd0;
    busWd.fpWriteFlags = 1'b0; busWd.fpFlagsValue = 5'd0; busWd.respReady = 1'b0;
    busWd.fflagsWrite = 1'b0; busWd.fflagsWriteValue = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (bus.reqReady !== 1'b1) begin errors++; $display("FAIL reset_reqReady: got %b want 1", bus.reqReady); end
    checks++; if (bus.fpEnable !== 1'b0) begin errors++; $display("FAIL reset_fpEnable: got %b want 0", bus.fpEnable); end
    checks++; if (bus.fpUnit !== UNIT_IDLE) begin errors++; $display("FAIL reset_fpUnit: got %h want f", bus.fpUnit); end
    checks++; if (bus.fpFlush !== 1'b0) begin errors++; $display("FAIL reset_fpFlush: got %b want 0", bus.fpFlush); end
    checks++; if (bus.respValid !== 1'b0) begin errors++; $display("FAIL reset_respValid: got %b want 0", bus.respValid); end
    checks++; if (bus.respTag !== 5'd0 || bus.respIntResult !== 32'd0 || bus.respFpResult !== 32'd0 || bus.respTimeout !== 1'b0)
      begin errors++; $display("FAIL reset_resp_fields: got tag=%h int=%h fp=%h to=%b want zeros", bus.respTag, bus.respIntResult, bus.respFpResult, bus.respTimeout); end
    checks++; if (bus.fflags !== 5'b00000) begin errors++; $display("FAIL reset_fflags: got %b want 00000", bus.fflags); end
    rst = 1'b0;
  endtask

  task automatic test_single_cycle();
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_MOVE; bus.reqTag = 5'd3;
    bus.fpDone = 1'b1; bus.fpIntResult = 32'h3F800000; bus.fpFpResult = 32'h00000011;
    bus.fpWriteFlags = 1'b0; bus.fpFlagsValue = 5'b11111; bus.respReady = 1'b1;
    step();
    bus.reqValid = 1'b0;
    checks++; if (bus.fpEnable !== 1'b1 || bus.fpUnit !== UNIT_MOVE || bus.reqReady !== 1'b0 || bus.respValid !== 1'b0)
      begin errors++; $display("FAIL single_exec: got en=%b unit=%h rdy=%b rv=%b want 1 5 0 0", bus.fpEnable, bus.fpUnit, bus.reqReady, bus.respValid); end
    step();
    bus.fpDone = 1'b0;
    checks++; if (bus.respValid !== 1'b1 || bus.respIntResult !== 32'h3F800000 || bus.respFpResult !== 32'h00000011)
      begin errors++; $display("FAIL single_resp: got rv=%b int=%h fp=%h want 1 3f800000 00000011", bus.respValid, bus.respIntResult, bus.respFpResult); end
    checks++; if (bus.respTag !== 5'd3 || bus.respTimeout !== 1'b0 || bus.fpEnable !== 1'b0 || bus.fpUnit !== UNIT_IDLE)
      begin errors++; $display("FAIL single_resp_ctl: got tag=%h to=%b en=%b unit=%h want 03 0 0 f", bus.respTag, bus.respTimeout, bus.fpEnable, bus.fpUnit); end
    step();
    checks++; if (bus.respValid !== 1'b0 || bus.reqReady !== 1'b1 || bus.fflags !== 5'b00000)
      begin errors++; $display("FAIL single_commit: got rv=%b rdy=%b fflags=%b want 0 1 00000", bus.respValid, bus.reqReady, bus.fflags); end
  endtask

  task automatic test_multi_cycle();
    int enCount;
    int earlyResp;
    enCount = 0; earlyResp = 0;
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_SQRT; bus.reqTag = 5'd7; bus.respReady = 1'b1;
    step();
    bus.reqValid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.fpEnable === 1'b1) enCount++;
      if (bus.respValid !== 1'b0) earlyResp++;
      if (k == 10) begin
        bus.fpDone = 1'b1; bus.fpFpResult = 32'h40000000; bus.fpIntResult = 32'h00000002;
        bus.fpWriteFlags = 1'b1; bus.fpFlagsValue = 5'b00001;
      end
      step();
    end
    bus.fpDone = 1'b0; bus.fpWriteFlags = 1'b0;
    checks++; if (enCount !== 10) begin errors++; $display("FAIL multi_enable_cycles: got %0d want 10", enCount); end
    checks++; if (earlyResp !== 0) begin errors++; $display("FAIL multi_early_resp: got %0d want 0", earlyResp); end
    checks++; if (bus.respValid !== 1'b1 || bus.respFpResult !== 32'h40000000 || bus.respTag !== 5'd7 || bus.fpEnable !== 1'b0)
      begin errors++; $display("FAIL multi_resp: got rv=%b fp=%h tag=%h en=%b want 1 40000000 07 0", bus.respValid, bus.respFpResult, bus.respTag, bus.fpEnable); end
    step();
    checks++; if (bus.fflags !== 5'b00001) begin errors++; $display("FAIL multi_fflags: got %b want 00001", bus.fflags); end
  endtask

  task automatic test_backpressure();
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_SQRT; bus.reqTag = 5'd9; bus.respReady = 1'b0;
    bus.fpDone = 1'b1; bus.fpIntResult = 32'hDEADBEEF; bus.fpWriteFlags = 1'b1; bus.fpFlagsValue = 5'b10000;
    step();
    bus.reqValid = 1'b0;
    step();
    bus.fpDone = 1'b0; bus.fpIntResult = 32'h0BADF00D; bus.fpWriteFlags = 1'b0; bus.fpFlagsValue = 5'b00000;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.respValid !== 1'b1 || bus.respIntResult !== 32'hDEADBEEF || bus.respTag !== 5'd9 || bus.reqReady !== 1'b0)
        begin errors++; $display("FAIL bp_stable_%0d: got rv=%b int=%h tag=%h rdy=%b want 1 deadbeef 09 0", k, bus.respValid, bus.respIntResult, bus.respTag, bus.reqReady); end
      step();
    end
    bus.respReady = 1'b1; bus.reqValid = 1'b1; bus.reqUnit = UNIT_MOVE; bus.reqTag = 5'd1;
    step();
    checks++; if (bus.fflags !== 5'b10001) begin errors++; $display("FAIL bp_accumulate: got %b want 10001", bus.fflags); end
    checks++; if (bus.reqReady !== 1'b1 || bus.fpEnable !== 1'b0)
      begin errors++; $display("FAIL bp_no_same_cycle_accept: got rdy=%b en=%b want 1 0", bus.reqReady, bus.fpEnable); end
    step();
    bus.reqValid = 1'b0;
    checks++; if (bus.fpEnable !== 1'b1 || bus.fpUnit !== UNIT_MOVE)
      begin errors++; $display("FAIL bp_next_accept: got en=%b unit=%h want 1 5", bus.fpEnable, bus.fpUnit); end
    bus.fpDone = 1'b1;
    step();
    bus.fpDone = 1'b0;
    step();
  endtask

  task automatic test_flush();
    int sawResp;
    sawResp = 0;
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_SQRT; bus.reqTag = 5'd4; bus.respReady = 1'b1;
    bus.fpWriteFlags = 1'b1; bus.fpFlagsValue = 5'b00110;
    step();
    bus.reqValid = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    bus.flush = 1'b1;
    #1;
    checks++; if (bus.fpFlush !== 1'b1) begin errors++; $display("FAIL flush_exec_pulse: got %b want 1", bus.fpFlush); end
    step();
    bus.flush = 1'b0;
    #1;
    checks++; if (bus.fpFlush !== 1'b0 || bus.reqReady !== 1'b1 || bus.fpEnable !== 1'b0 || bus.fpUnit !== UNIT_IDLE)
      begin errors++; $display("FAIL flush_exec_idle: got fl=%b rdy=%b en=%b unit=%h want 0 1 0 f", bus.fpFlush, bus.reqReady, bus.fpEnable, bus.fpUnit); end
    bus.fpDone = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (bus.respValid !== 1'b0) sawResp++;
      step();
    end
    bus.fpDone = 1'b0;
    checks++; if (sawResp !== 0 || bus.fflags !== 5'b10001)
      begin errors++; $display("FAIL flush_exec_noresp: got resp=%0d fflags=%b want 0 10001", sawResp, bus.fflags); end
    // flush in IDLE blocks acceptance
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_SQRT; bus.flush = 1'b1;
    step();
    bus.reqValid = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.fpEnable !== 1'b0 || bus.reqReady !== 1'b1)
      begin errors++; $display("FAIL flush_idle_block: got en=%b rdy=%b want 0 1", bus.fpEnable, bus.reqReady); end
    // flush in RESP together with respReady commits nothing
    bus.reqValid = 1'b1; bus.respReady = 1'b0; bus.fpDone = 1'b1;
    bus.fpWriteFlags = 1'b1; bus.fpFlagsValue = 5'b00100;
    step();
    bus.reqValid = 1'b0;
    step();
    bus.fpDone = 1'b0; bus.fpWriteFlags = 1'b0;
    bus.respReady = 1'b1; bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++; if (bus.respValid !== 1'b0 || bus.fflags !== 5'b10001)
      begin errors++; $display("FAIL flush_resp_noflags: got rv=%b fflags=%b want 0 10001", bus.respValid, bus.fflags); end
  endtask

  task automatic test_watchdog();
    logic expFlush;
    busWd.reqValid = 1'b1; busWd.reqUnit = UNIT_SQRT; busWd.reqTag = 5'd2;
    busWd.fpIntResult = 32'h12345678; busWd.fpFpResult = 32'h87654321;
    busWd.fpWriteFlags = 1'b1; busWd.fpFlagsValue = 5'b11111; busWd.respReady = 1'b0;
    step();
    busWd.reqValid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      expFlush = (k == 8) ? 1'b1 : 1'b0;
      checks++; if (busWd.fpFlush !== expFlush || busWd.fpEnable !== 1'b1)
        begin errors++; $display("FAIL wd_exec_cycle_%0d: got fl=%b en=%b want %b 1", k, busWd.fpFlush, busWd.fpEnable, expFlush); end
      step();
    end
    checks++; if (busWd.respValid !== 1'b1 || busWd.respTimeout !== 1'b1 || busWd.respIntResult !== 32'd0 || busWd.respFpResult !== 32'd0 || busWd.respTag !== 5'd2)
      begin errors++; $display("FAIL wd_resp: got rv=%b to=%b int=%h fp=%h tag=%h want 1 1 0 0 02", busWd.respValid, busWd.respTimeout, busWd.respIntResult, busWd.respFpResult, busWd.respTag); end
    checks++; if (busWd.fpFlush !== 1'b0) begin errors++; $display("FAIL wd_flush_single: got %b want 0", busWd.fpFlush); end
    busWd.respReady = 1'b1;
    step();
    busWd.respReady = 1'b0; busWd.fpWriteFlags = 1'b0;
    checks++; if (busWd.fflags !== 5'b00000 || busWd.reqReady !== 1'b1)
      begin errors++; $display("FAIL wd_fflags: got fflags=%b rdy=%b want 00000 1", busWd.fflags, busWd.reqReady); end
  endtask

  task automatic test_csr_collision();
    bus.fflagsWrite = 1'b1; bus.fflagsWriteValue = 5'b00000;
    step();
    bus.fflagsWrite = 1'b0;
    checks++; if (bus.fflags !== 5'b00000) begin errors++; $display("FAIL csr_write_alone: got %b want 00000", bus.fflags); end
    bus.reqValid = 1'b1; bus.reqUnit = UNIT_SQRT; bus.reqTag = 5'd6; bus.respReady = 1'b0;
    bus.fpDone = 1'b1; bus.fpWriteFlags = 1'b1; bus.fpFlagsValue = 5'b00001;
    step();
    bus.reqValid = 1'b0;
    step();
    bus.fpDone = 1'b0; bus.fpWriteFlags = 1'b0; bus.fpFlagsValue = 5'b00000;
    bus.respReady = 1'b1; bus.fflagsWrite = 1'b1; bus.fflagsWriteValue = 5'b00100;
    step();
    bus.fflagsWrite = 1'b0; bus.respReady = 1'b0;
    checks++; if (bus.fflags !== 5'b00101) begin errors++; $display("FAIL csr_collision: got %b want 00101", bus.fflags); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (bus.fflags !== 5'b00000 || bus.reqReady !== 1'b1)
      begin errors++; $display("FAIL csr_reset_after: got fflags=%b rdy=%b want 00000 1", bus.fflags, bus.reqReady); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clearInputs();
    test_reset();
    test_single_cycle();
    test_multi_cycle();
    test_backpressure();
    test_flush();
    test_watchdog();
    test_csr_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
